// File: rtl/data_mem_controller.sv
// Data-memory slave for the CPU MEM stage: turns single-cycle read/write pulses into
// byte-enabled accesses on one 32-bit BRAM, with lane alignment, load extension and fault reporting.
`timescale 1ns/1ps

module data_mem_controller #(
  parameter int ADDR_WIDTH   = 14,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  dispatch_read_in,
  input  logic                  dispatch_write_in,
  input  logic [31:0]           addr_in,
  input  logic [1:0]            mem_width_in,
  input  logic                  signed_in,
  input  logic [31:0]           write_data_in,
  output logic [31:0]           read_data_out,
  output logic                  busy_out,
  output logic                  fault_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic [31:0]           bram_din_out,
  output logic [3:0]            bram_we_out,
  input  logic [31:0]           bram_dout_in,
  output logic [1:0]            state_dbg
);

  localparam int CW = $clog2(BRAM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    READ_WAIT = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [1:0]    lane_q;
  logic [1:0]    width_q;
  logic          signed_q;

  logic [1:0]  lane;
  logic        dispatch;
  logic        fault_now;
  logic [3:0]  we_next;
  logic [31:0] din_next;
  logic [31:0] shifted;
  logic [31:0] load_value;

  // Handshake: a request is a one-cycle pulse on dispatch_read_in or dispatch_write_in
  // and is taken only when the FSM is IDLE; busy_out rises combinationally in that same
  // cycle and stays high until the transaction has fully retired.
  assign busy_out  = (state != IDLE) | dispatch_read_in | dispatch_write_in;
  assign state_dbg = state;

  assign lane     = addr_in[1:0];
  assign dispatch = dispatch_read_in | dispatch_write_in;

  always_comb begin
    fault_now = 1'b0;
    if (mem_width_in == 2'd3) fault_now = 1'b1;
    if (mem_width_in == 2'd1 && addr_in[0]) fault_now = 1'b1;
    if (mem_width_in == 2'd2 && addr_in[1:0] != 2'b00) fault_now = 1'b1;
    if ((addr_in >> (ADDR_WIDTH + 2)) != 32'd0) fault_now = 1'b1;
    if (dispatch_read_in && dispatch_write_in) fault_now = 1'b1;
  end

  // Store data is replicated across lanes so the byte enables alone select the target bytes.
  always_comb begin
    we_next  = 4'b1111;
    din_next = write_data_in;
    case (mem_width_in)
      2'd0: begin
        we_next  = 4'b0001 << lane;
        din_next = {4{write_data_in[7:0]}};
      end
      2'd1: begin
        we_next  = 4'b0011 << lane;
        din_next = {2{write_data_in[15:0]}};
      end
      default: begin
        we_next  = 4'b1111;
        din_next = write_data_in;
      end
    endcase
  end

  always_comb begin
    shifted    = bram_dout_in >> {lane_q, 3'b000};
    load_value = bram_dout_in;
    case (width_q)
      2'd0:    load_value = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_value = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_value = bram_dout_in;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      counter       <= '0;
      lane_q        <= 2'd0;
      width_q       <= 2'd0;
      signed_q      <= 1'b0;
      read_data_out <= 32'd0;
      fault_out     <= 1'b0;
      bram_we_out   <= 4'b0000;
      bram_addr_out <= '0;
      bram_din_out  <= 32'd0;
    end else begin
      fault_out <= 1'b0;
      case (state)
        IDLE: begin
          if (dispatch) begin
            if (fault_now) begin
              fault_out <= 1'b1;
              if (dispatch_read_in) read_data_out <= 32'd0;
            end else if (dispatch_write_in) begin
              bram_addr_out <= addr_in[ADDR_WIDTH+1:2];
              bram_we_out   <= we_next;
              bram_din_out  <= din_next;
              state         <= WRITE;
            end else begin
              bram_addr_out <= addr_in[ADDR_WIDTH+1:2];
              lane_q        <= lane;
              width_q       <= mem_width_in;
              signed_q      <= signed_in;
              counter       <= '0;
              state         <= READ_WAIT;
            end
          end
        end
        WRITE: begin
          bram_we_out <= 4'b0000;
          state       <= IDLE;
        end
        READ_WAIT: begin
          // counter==0 is the cycle the address is first presented to the BRAM.
          if (counter == CW'(BRAM_LATENCY)) begin
            read_data_out <= load_value;
            state         <= IDLE;
          end else begin
            counter <= counter + CW'(1);
          end
        end
        default: begin
          bram_we_out <= 4'b0000;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: three instances (BRAM latency 1, 2, 3) run in lockstep
// against a byte-array reference memory; directed cases first, then random transactions.
`timescale 1ns/1ps

module tb_data_mem_controller;
  localparam int AW = 14;
  localparam int NB = 4 * (1 << AW);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        drd = 1'b0;
  logic        dwr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [1:0]  width = 2'd0;
  logic        sgn = 1'b0;
  logic [31:0] wd = 32'd0;

  logic [2:0]          busy_v;
  logic [2:0]          fault_v;
  logic [2:0][31:0]    rd_v;
  logic [2:0][31:0]    din_v;
  logic [2:0][31:0]    dout_v;
  logic [2:0][AW-1:0]  baddr_v;
  logic [2:0][3:0]     we_v;
  logic [2:0][1:0]     st_v;

  bit [31:0] mem [0:(1<<AW)-1];
  bit [7:0]  ref_bytes [0:NB-1];
  logic [31:0] exp_rd = 32'd0;

  int vectors = 0;
  int miscompares = 0;

  for (genvar g = 0; g < 3; g++) begin : lat_g
    localparam int L = g + 1;
    bit [31:0] dpipe [L];

    data_mem_controller #(.ADDR_WIDTH(AW), .BRAM_LATENCY(L)) u_dut (
      .clk_in(clk),
      .rst_in(rst),
      .dispatch_read_in(drd),
      .dispatch_write_in(dwr),
      .addr_in(addr),
      .mem_width_in(width),
      .signed_in(sgn),
      .write_data_in(wd),
      .read_data_out(rd_v[g]),
      .busy_out(busy_v[g]),
      .fault_out(fault_v[g]),
      .bram_addr_out(baddr_v[g]),
      .bram_din_out(din_v[g]),
      .bram_we_out(we_v[g]),
      .bram_dout_in(dout_v[g]),
      .state_dbg(st_v[g])
    );

    // Synchronous BRAM read path with L cycles of latency.
    always @(posedge clk) begin
      dpipe[0] <= mem[baddr_v[g]];
      for (int k = 1; k < L; k++) dpipe[k] <= dpipe[k-1];
    end
    assign dout_v[g] = dpipe[L-1];
  end

  always @(posedge clk) begin
    for (int j = 0; j < 4; j++)
      if (we_v[1][j]) mem[baddr_v[1]][8*j +: 8] <= din_v[1][8*j +: 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_fault(input logic r, input logic w, input logic [31:0] a,
                                   input logic [1:0] wdth);
    return (wdth == 2'd3) || (wdth == 2'd1 && a % 2 != 0) || (wdth == 2'd2 && a % 4 != 0) ||
           (a >= 32'(NB)) || (r && w);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] wdth,
                                           input logic s);
    int n;
    logic [31:0] val;
    n = 1 << wdth;
    val = 32'd0;
    for (int i = 0; i < n; i++) val = val | (32'(ref_bytes[a + i]) << (8 * i));
    if (n < 4 && s && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
    return val;
  endfunction

  task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                         input logic [1:0] wdth, input logic s, input logic [31:0] d);
    bit flt;
    int n;
    int blen [3];
    int fcnt;
    int wcyc;
    logic [3:0]    we_seen;
    logic [31:0]   din_seen;
    logic [AW-1:0] addr_seen;
    logic [3:0]    exp_we;
    logic [31:0]   exp_din;

    flt = ref_fault(r, w, a, wdth);
    n = 1 << wdth;
    @(negedge clk);
    drd = r; dwr = w; addr = a; width = wdth; sgn = s; wd = d;
    #1;
    check("busy_on_dispatch", {29'd0, busy_v}, 32'd7);
    @(posedge clk);
    #1;
    drd = 1'b0; dwr = 1'b0; addr = $urandom; wd = $urandom; sgn = ~s; width = 2'($urandom);
    blen = '{0, 0, 0};
    fcnt = 0; wcyc = 0; we_seen = 4'd0; din_seen = 32'd0; addr_seen = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (busy_v[g]) blen[g]++;
      if (fault_v[1]) fcnt++;
      if (we_v[1] != 4'd0) begin
        wcyc++;
        we_seen = we_v[1]; din_seen = din_v[1]; addr_seen = baddr_v[1];
      end
    end
    check("fault_pulses", 32'(fcnt), flt ? 32'd1 : 32'd0);
    for (int g = 0; g < 3; g++)
      check($sformatf("busy_after_dispatch_lat%0d", g + 1), 32'(blen[g]),
            flt ? 32'd0 : (w ? 32'd1 : 32'(g + 2)));
    check("write_enable_cycles", 32'(wcyc), (!flt && w) ? 32'd1 : 32'd0);
    if (!flt && w) begin
      exp_we = 4'(((1 << n) - 1) << (a % 4));
      for (int j = 0; j < 4; j++) exp_din[8*j +: 8] = d[8*(j % n) +: 8];
      check("bram_we", {28'd0, we_seen}, {28'd0, exp_we});
      check("bram_din", din_seen, exp_din);
      check("bram_addr", 32'(addr_seen), a / 4);
      for (int i = 0; i < n; i++) ref_bytes[a + i] = d[8*i +: 8];
    end
    if (r) exp_rd = flt ? 32'd0 : ref_load(a, wdth, s);
    for (int g = 0; g < 3; g++)
      check($sformatf("read_data_lat%0d", g + 1), rd_v[g], exp_rd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  wdth;
    logic        r, w;
    int          k, we_hits;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_read_data", rd_v[1], 32'd0);
    check("reset_busy", {29'd0, busy_v}, 32'd0);
    check("reset_fault", {29'd0, fault_v}, 32'd0);
    check("reset_we", {28'd0, we_v[1]}, 32'd0);
    check("reset_bram_addr", 32'(baddr_v[1]), 32'd0);
    check("reset_bram_din", din_v[1], 32'd0);

    run_txn(0, 1, 32'h10, 2'd2, 0, 32'hDEAD_BEEF);
    run_txn(1, 0, 32'h10, 2'd2, 0, 32'h0);
    run_txn(0, 1, 32'h13, 2'd0, 0, 32'h0000_0080);
    run_txn(1, 0, 32'h13, 2'd0, 1, 32'h0);
    run_txn(1, 0, 32'h13, 2'd0, 0, 32'h0);
    run_txn(0, 1, 32'h22, 2'd1, 0, 32'h0000_8001);
    run_txn(1, 0, 32'h22, 2'd1, 1, 32'h0);
    run_txn(1, 0, 32'h20, 2'd1, 1, 32'h0);
    run_txn(1, 0, 32'h10, 2'd2, 0, 32'h0);
    run_txn(1, 0, 32'h01, 2'd1, 0, 32'h0);
    run_txn(0, 1, 32'h06, 2'd2, 0, 32'h1234_5678);
    run_txn(1, 0, 32'h10, 2'd2, 0, 32'h0);
    run_txn(1, 0, 32'h0001_0000, 2'd2, 0, 32'h0);
    run_txn(1, 0, 32'h10, 2'd2, 0, 32'h0);
    run_txn(1, 0, 32'h0, 2'd3, 0, 32'h0);
    run_txn(1, 0, 32'h10, 2'd2, 0, 32'h0);
    run_txn(1, 1, 32'h0, 2'd2, 0, 32'hFFFF_FFFF);
    run_txn(0, 1, 32'(NB - 4), 2'd2, 0, 32'hA5C3_0F69);
    run_txn(1, 0, 32'(NB - 4), 2'd2, 0, 32'h0);
    run_txn(0, 1, 32'(NB), 2'd0, 0, 32'h0000_0011);
    run_txn(1, 0, 32'h06, 2'd2, 0, 32'h0);

    // A second request while a read is outstanding must be dropped.
    run_txn(1, 0, 32'h10, 2'd2, 0, 32'h0);
    run_txn(1, 0, 32'h22, 2'd1, 0, 32'h0);
    @(negedge clk);
    drd = 1'b1; addr = 32'h10; width = 2'd2; sgn = 1'b0;
    @(posedge clk);
    #1;
    drd = 1'b0;
    @(negedge clk);
    dwr = 1'b1; addr = 32'h10; width = 2'd2; wd = 32'h1234_5678;
    @(posedge clk);
    #1;
    dwr = 1'b0;
    @(negedge clk);
    drd = 1'b1; addr = 32'h13; width = 2'd0; sgn = 1'b1;
    @(posedge clk);
    #1;
    drd = 1'b0;
    we_hits = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (we_v[1] != 4'd0) we_hits++;
    end
    exp_rd = ref_load(32'h10, 2'd2, 1'b0);
    check("ignored_dispatch_no_write", 32'(we_hits), 32'd0);
    for (int g = 0; g < 3; g++)
      check($sformatf("ignored_dispatch_read_lat%0d", g + 1), rd_v[g], exp_rd);
    run_txn(1, 0, 32'h10, 2'd2, 0, 32'h0);

    // Reset while a read is waiting on the BRAM.
    @(negedge clk);
    drd = 1'b1; addr = 32'h22; width = 2'd1; sgn = 1'b1;
    @(posedge clk);
    #1;
    drd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    exp_rd = 32'd0;
    check("reset_midread_data", rd_v[1], 32'd0);
    check("reset_midread_busy", {29'd0, busy_v}, 32'd0);
    check("reset_midread_addr", 32'(baddr_v[1]), 32'd0);
    repeat (6) @(negedge clk);
    check("reset_midread_stays", rd_v[1], 32'd0);

    for (int t = 0; t < 160; t++) begin
      k = $urandom_range(0, 9);
      if (k == 0) a = $urandom;
      else if (k == 1) a = 32'(NB - 8) + 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, 63));
      wdth = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && wdth != 2'd3) a = a & ~((32'd1 << wdth) - 32'd1);
      k = $urandom_range(0, 19);
      r = (k == 0) || (k < 10);
      w = (k == 0) || (k >= 10);
      run_txn(r, w, a, wdth, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
